alu: RTL and testbench
======================

Name: alu

Overview:
- 16-bit ALU for the RISC machine datapath. It sits between the A/B operand registers and the C result register.
- The result `out` and zero flag `Z` are purely combinational.
- A small status register captures the Z/N/V flags on the clock edge when `loads` is asserted. The controller uses it for compare/branch decisions.

Parameters:
- WIDTH, 16, datapath width in bits. All arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock for the status register.
- rst_n  input  1  asynchronous active-low reset.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B (already shifted upstream).
- ALUop  input  2  operation select.
- loads  input  1  status-register load enable.
- out  output  WIDTH  combinational result.
- Z  output  1  combinational zero flag of `out`.
- status  output  3  registered flags {V,N,Z}; bit0=Z, bit1=N, bit2=V.

Behaviour:
- Combinational path, zero latency; `out` and `Z` settle in the same delta as input changes, with no clock dependency:
  - ALUop=00: out = Ain + Bin, carry discarded (wraps mod 2^16).
  - ALUop=01: out = Ain − Bin, two's-complement, borrow discarded (wraps).
  - ALUop=10: out = Ain & Bin, bitwise.
  - ALUop=11: out = ~Bin, bitwise. Ain is ignored.
  - ALUop containing X/Z: out = all-X. Not a legal use.
- Z = 1 iff out == 0, for every ALUop. E.g. ALUop=11 with Bin=16'hFFFF gives Z=1.
- Combinational flags (internal):
  - N = out[15].
  - V = signed overflow, defined for ALUop=00/01 only:
    - add: Ain[15]==Bin[15] && out[15]!=Ain[15].
    - sub: Ain[15]!=Bin[15] && out[15]!=Ain[15].
    - ALUop=10/11: V=0.
- Status register:
  - rst_n low: status = 3'b000 immediately (asynchronous), held while low.
  - Rising clk with rst_n high and loads=1: status <= {V,N,Z} of the current inputs.
  - Rising clk with loads=0: status holds.
  - Reset deassertion takes effect at the next clk edge. A loads=1 on that same edge loads normally.
  - Reset asserted mid-operation clears status regardless of loads. The combinational `out`/`Z` are unaffected by reset.
- No internal state other than `status`. Bus width is never extended; there is no carry-out port.

Test Plan:
- Add: Ain=10, Bin=15, ALUop=00 -> out=25, Z=0. Then Ain=16'hFFFF, Bin=1 -> out=0, Z=1 (wrap).
- Subtract: Ain=20, Bin=15, ALUop=01 -> out=5, Z=0. Then Ain=Bin=0 -> out=0, Z=1. Then Ain=0, Bin=1 -> out=16'hFFFF, N=1.
- Logic ops:
  - AND: Ain=5, Bin=3, ALUop=10 -> out=1, Z=0. Then Ain=Bin=0 -> out=0, Z=1.
  - NOT: Bin=10, ALUop=11 -> out=16'hFFF5, Z=0 (any Ain). Then Bin=16'hFFFF -> out=0, Z=1.
- Zero sweep: Ain=Bin=0, ALUop=00, 01, 10 in turn -> out=0 and Z=1 for each.
- Status/overflow: Ain=16'h7FFF, Bin=1, ALUop=00, loads=1, clock -> status=3'b110. Then Ain=16'h8000, Bin=1, ALUop=01 -> status=3'b100. Then loads=0 with new inputs -> status unchanged.
- Reset: load status=3'b001, assert rst_n=0 between edges -> status=0 immediately while `out` still tracks inputs. Deassert, then loads=1 on the next edge -> normal capture.

Source files
------------

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_if
// Description : Operand/result bundle between the datapath controller and
//               the ALU: operands, op select, status load enable, result,
//               zero flag and the registered status flags.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [1:0]       ALUop;
    logic             loads;
    logic [WIDTH-1:0] out;
    logic             Z;
    logic [2:0]       status;

    // Controller side: drives operands and controls, observes results
    modport master (
        output Ain, Bin, ALUop, loads,
        input  out, Z, status
    );

    // ALU side: consumes operands and controls, produces results
    modport slave (
        input  Ain, Bin, ALUop, loads,
        output out, Z, status
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : WIDTH-bit ALU (add / sub / and / not-B) with a combinational
//               result and zero flag, plus a 3-bit status register that
//               captures {V,N,Z} when loads is asserted.
// Revision    : 1.0  initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_if.slave      bus
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             neg_flag;
    logic             ovf_flag;
    logic [2:0]       status_q;

    // Result mux; carry/borrow fall off the top, an unknown op gives all-X
    always_comb begin
        result = '0;
        case (bus.ALUop)
            OP_ADD:  result = bus.Ain + bus.Bin;
            OP_SUB:  result = bus.Ain - bus.Bin;
            OP_AND:  result = bus.Ain & bus.Bin;
            OP_NOT:  result = ~bus.Bin;
            default: result = 'x;
        endcase
    end

    // Flags derived from the result; overflow only meaningful for add/sub
    always_comb begin
        zero_flag = (result == '0);
        neg_flag  = result[WIDTH-1];
        ovf_flag  = 1'b0;
        case (bus.ALUop)
            OP_ADD: ovf_flag = (bus.Ain[WIDTH-1] == bus.Bin[WIDTH-1]) &&
                               (result[WIDTH-1]  != bus.Ain[WIDTH-1]);
            OP_SUB: ovf_flag = (bus.Ain[WIDTH-1] != bus.Bin[WIDTH-1]) &&
                               (result[WIDTH-1]  != bus.Ain[WIDTH-1]);
            default: ovf_flag = 1'b0;
        endcase
    end

    // Status register: async clear, load {V,N,Z} when loads is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 3'b000;
        end else if (bus.loads) begin
            status_q <= {ovf_flag, neg_flag, zero_flag};
        end
    end

    assign bus.out    = result;
    assign bus.Z      = zero_flag;
    assign bus.status = status_q;
endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu: directed cases and randomized
//               operations against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_if #(.WIDTH(16)) bus ();

    alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from plain integer arithmetic modulo 2^16
    function automatic logic [15:0] ref_out(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
        int r;
        case (op)
            2'd0:    r = (int'(a) + int'(b)) % 65536;
            2'd1:    r = (int'(a) - int'(b) + 65536) % 65536;
            2'd2:    r = int'(a & b);
            default: r = int'(~b);
        endcase
        return r[15:0];
    endfunction

    // Reference overflow: true signed result outside the 16-bit range
    function automatic logic ref_v(input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] op);
        int sa;
        int sb;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 2'd0)      r = sa + sb;
        else if (op == 2'd1) r = sa - sb;
        else                 return 1'b0;
        return (r > 32767) || (r < -32768);
    endfunction

    function automatic logic [2:0] ref_status(input logic [15:0] a, input logic [15:0] b,
                                              input logic [1:0] op);
        logic [15:0] o;
        o = ref_out(a, b, op);
        return {ref_v(a, b, op), o[15], (o == 16'h0000)};
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic ld);
        bus.Ain   = a;
        bus.Bin   = b;
        bus.ALUop = op;
        bus.loads = ld;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(16'd10, 16'd15, 2'b00, 1'b1);
        #1;
        total++;
        if (bus.status !== 3'b000) begin
            bad++; $display("FAIL reset_status got=%b want=000", bus.status);
        end
        total++;
        if (bus.out !== 16'd25) begin
            bad++; $display("FAIL reset_out got=%h want=%h", bus.out, 16'd25);
        end
        @(posedge clk); #1;
        total++;
        if (bus.status !== 3'b000) begin
            bad++; $display("FAIL reset_hold got=%b want=000", bus.status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.loads = 1'b0;
    endtask

    task automatic test_add();
        @(negedge clk);
        drive(16'd10, 16'd15, 2'b00, 1'b0); #1;
        total++;
        if (bus.out !== 16'd25 || bus.Z !== 1'b0) begin
            bad++; $display("FAIL add out=%h Z=%b want out=0019 Z=0", bus.out, bus.Z);
        end
        drive(16'hFFFF, 16'd1, 2'b00, 1'b0); #1;
        total++;
        if (bus.out !== 16'h0000 || bus.Z !== 1'b1) begin
            bad++; $display("FAIL add_wrap out=%h Z=%b want out=0000 Z=1", bus.out, bus.Z);
        end
    endtask

    task automatic test_sub();
        @(negedge clk);
        drive(16'd20, 16'd15, 2'b01, 1'b0); #1;
        total++;
        if (bus.out !== 16'd5 || bus.Z !== 1'b0) begin
            bad++; $display("FAIL sub out=%h Z=%b want out=0005 Z=0", bus.out, bus.Z);
        end
        drive(16'd0, 16'd0, 2'b01, 1'b0); #1;
        total++;
        if (bus.out !== 16'h0000 || bus.Z !== 1'b1) begin
            bad++; $display("FAIL sub_zero out=%h Z=%b want out=0000 Z=1", bus.out, bus.Z);
        end
        drive(16'd0, 16'd1, 2'b01, 1'b1);
        @(posedge clk); #1;
        total++;
        if (bus.out !== 16'hFFFF || bus.status !== 3'b010) begin
            bad++; $display("FAIL sub_neg out=%h status=%b want out=ffff status=010",
                            bus.out, bus.status);
        end
        bus.loads = 1'b0;
    endtask

    task automatic test_logic();
        @(negedge clk);
        drive(16'd5, 16'd3, 2'b10, 1'b0); #1;
        total++;
        if (bus.out !== 16'd1 || bus.Z !== 1'b0) begin
            bad++; $display("FAIL and out=%h Z=%b want out=0001 Z=0", bus.out, bus.Z);
        end
        drive(16'd0, 16'd0, 2'b10, 1'b0); #1;
        total++;
        if (bus.out !== 16'h0000 || bus.Z !== 1'b1) begin
            bad++; $display("FAIL and_zero out=%h Z=%b want out=0000 Z=1", bus.out, bus.Z);
        end
        drive(16'h1234, 16'd10, 2'b11, 1'b0); #1;
        total++;
        if (bus.out !== 16'hFFF5 || bus.Z !== 1'b0) begin
            bad++; $display("FAIL not out=%h Z=%b want out=fff5 Z=0", bus.out, bus.Z);
        end
        drive(16'hABCD, 16'hFFFF, 2'b11, 1'b0); #1;
        total++;
        if (bus.out !== 16'h0000 || bus.Z !== 1'b1) begin
            bad++; $display("FAIL not_zero out=%h Z=%b want out=0000 Z=1", bus.out, bus.Z);
        end
    endtask

    task automatic test_zero_sweep();
        @(negedge clk);
        for (int op = 0; op < 3; op++) begin
            drive(16'd0, 16'd0, 2'(op), 1'b0); #1;
            total++;
            if (bus.out !== 16'h0000 || bus.Z !== 1'b1) begin
                bad++; $display("FAIL zero_sweep op=%0d out=%h Z=%b want out=0000 Z=1",
                                op, bus.out, bus.Z);
            end
        end
    endtask

    task automatic test_status();
        @(negedge clk);
        drive(16'h7FFF, 16'd1, 2'b00, 1'b1);
        @(posedge clk); #1;
        total++;
        if (bus.status !== 3'b110) begin
            bad++; $display("FAIL status_add_ovf got=%b want=110", bus.status);
        end
        @(negedge clk);
        drive(16'h8000, 16'd1, 2'b01, 1'b1);
        @(posedge clk); #1;
        total++;
        if (bus.status !== 3'b100) begin
            bad++; $display("FAIL status_sub_ovf got=%b want=100", bus.status);
        end
        @(negedge clk);
        drive(16'd0, 16'd0, 2'b00, 1'b0);
        @(posedge clk); #1;
        total++;
        if (bus.status !== 3'b100) begin
            bad++; $display("FAIL status_hold got=%b want=100", bus.status);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(16'd0, 16'd0, 2'b00, 1'b1);
        @(posedge clk); #1;
        total++;
        if (bus.status !== 3'b001) begin
            bad++; $display("FAIL mid_preload got=%b want=001", bus.status);
        end
        #2;
        rst_n = 1'b0;
        drive(16'd3, 16'd4, 2'b00, 1'b1);
        #1;
        total++;
        if (bus.status !== 3'b000 || bus.out !== 16'd7) begin
            bad++; $display("FAIL mid_reset status=%b out=%h want status=000 out=0007",
                            bus.status, bus.out);
        end
        @(posedge clk); #1;
        total++;
        if (bus.status !== 3'b000) begin
            bad++; $display("FAIL mid_reset_hold got=%b want=000", bus.status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h7FFF, 16'd1, 2'b00, 1'b1);
        @(posedge clk); #1;
        total++;
        if (bus.status !== 3'b110) begin
            bad++; $display("FAIL post_reset_load got=%b want=110", bus.status);
        end
    endtask

    task automatic test_random();
        logic [2:0]  exp_status;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        ld;
        logic [15:0] exp_out;
        exp_status = bus.status === 3'b110 ? 3'b110 : 3'b000;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       a = 16'h7FFF;
                1:       a = 16'h8000;
                default: a = 16'($urandom);
            endcase
            b  = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
            op = 2'($urandom_range(0, 3));
            ld = 1'($urandom);
            drive(a, b, op, ld);
            exp_out = ref_out(a, b, op);
            #1;
            total++;
            if (bus.out !== exp_out || bus.Z !== (exp_out == 16'h0000)) begin
                bad++; $display("FAIL rand_comb a=%h b=%h op=%b out=%h Z=%b want out=%h",
                                a, b, op, bus.out, bus.Z, exp_out);
            end
            if (ld) exp_status = ref_status(a, b, op);
            @(posedge clk); #1;
            total++;
            if (bus.status !== exp_status) begin
                bad++; $display("FAIL rand_status a=%h b=%h op=%b ld=%b got=%b want=%b",
                                a, b, op, ld, bus.status, exp_status);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_zero_sweep();
        test_status();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
